guvm_instr_feeder: RTL
======================

// Module: guvm_instr_feeder
// PURPOSE
//  Instruction-side memory responder between the GUVM driver and the core's instruction fetch port.
//  Driver pushes instruction words into a FIFO; block answers core fetches (req/gnt/rvalid) in order.
//  Returns a NOP when the FIFO is empty. Keeps the core fed with straight-line test code.
// PARAMETERS
//  DEPTH      16            FIFO entries (power of 2, >=2)
//  DATA_W     32            instruction width (matches core INSTR_RDATA_WIDTH)
//  RVALID_LAT 1             cycles from grant to rvalid (1..4)
//  MAX_OUTST  2             max granted-but-unanswered fetches (1..RVALID_LAT+1)
//  NOP_INSTR  32'h00000013  word returned on underflow (addi x0,x0,0)
//  BOOT_ADDR  32'h00000080  first expected fetch address (address check only)
// PORTS
//  clk_i          in   1                clock
//  rst_i          in   1                async reset, active-high
//  enable_i       in   1                start serving fetches
//  flush_i        in   1                discard queued words, drain in-flight
//  push_valid_i   in   1                driver word valid
//  push_data_i    in   DATA_W           driver instruction word
//  push_ready_o   out  1                FIFO not full
//  instr_req_i    in   1                core fetch request
//  instr_addr_i   in   32               core fetch address
//  instr_gnt_o    out  1                fetch grant
//  instr_rvalid_o out  1                response valid
//  instr_rdata_o  out  DATA_W           response word
//  count_o        out  $clog2(DEPTH)+1  FIFO occupancy
//  underflow_o    out  16               NOPs served (saturating)
//  addr_err_o     out  1                sticky address-mismatch flag
// BEHAVIOUR
//  Reset: all outputs 0 except push_ready_o=1; FIFO empty; FSM=IDLE; outstanding=0.
//  FSM: IDLE -(enable_i)-> RUN; RUN -(flush_i)-> DRAIN; DRAIN -(outstanding==0)-> IDLE.
//    flush_i has priority over enable_i.
//  instr_gnt_o = (state==RUN) && instr_req_i && (outstanding<MAX_OUTST); combinational.
//  On grant: pop FIFO head into the response delay line. If empty, load NOP_INSTR; underflow_o+1, saturates at 16'hFFFF.
//  Delay line: instr_rvalid_o/instr_rdata_o asserted exactly RVALID_LAT cycles after grant, one cycle each, in grant order.
//  outstanding: +1 on grant, -1 on rvalid; both in the same cycle leaves it unchanged.
//  push_ready_o = !full, from registered count.
//  Push when full: word dropped, count unchanged.
//  Push and pop in the same cycle: count unchanged; legal when full, since the pop frees the slot first.
//  Push into an empty FIFO during a grant cycle: no bypass. That fetch gets NOP; the word is served on the next grant.
//  Entering DRAIN: FIFO cleared on the same edge. Pushes during DRAIN are ignored. In-flight responses still complete with their loaded data.
//  Async reset mid-fetch: delay line cleared; no rvalid issued for pre-reset grants.
//  Pointers wrap modulo DEPTH. count_o ranges 0..DEPTH.
// CONFIGURATION
//  GUVM_FEEDER_ADDR_CHECK_EN defined:
//    expected PC register, reset and IDLE->RUN value BOOT_ADDR; +4 per grant.
//    On grant with instr_addr_i != PC: addr_err_o set, held until reset.
//  Undefined: no PC register; addr_err_o tied 0.
// STRUCTURE
//  Package guvm_feeder_pkg holds:
//    typedef enum logic [1:0] {IDLE, RUN, DRAIN} feeder_state_e;
//    localparam NOP_RV32 = 32'h00000013;
//    the response-slot struct {valid, data}.
//  Sub-module guvm_sync_fifo (DEPTH, DATA_W): push/pop/full/empty/count, no bypass.
//  Top holds the FSM, grant logic, delay line, counters and the optional PC check.
// TESTING
//  1. Reset, push 3 words (A,B,C), enable, req held high -> rdata A,B,C on consecutive cycles, each RVALID_LAT after its grant; count_o 3->0.
//  2. Empty FIFO, enable, 2 grants -> rdata 32'h00000013 twice; underflow_o==2.
//  3. Push 16 words (DEPTH=16), push a 17th -> push_ready_o=0, 17th dropped; count_o==16.
//  4. Two grants outstanding at RVALID_LAT=2, MAX_OUTST=2 -> 3rd req not granted until first rvalid.
//  5. Flush with 1 in flight and 5 queued -> in-flight word returned, count_o=0, FSM reaches IDLE, no further grants.
//  6. With GUVM_FEEDER_ADDR_CHECK_EN: fetch 0x80 then 0x88 -> addr_err_o=1 after 2nd grant, stays 1.

Source files
------------

// File: rtl/guvm_feeder_pkg.sv
// Shared types for the GUVM instruction feeder: FSM states, the NOP encoding,
// and the response slot carried through the grant-to-rvalid delay line.
package guvm_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } feeder_state_e;

  localparam logic [31:0] NOP_RV32 = 32'h00000013;
  localparam int          SLOT_W   = 32;

  typedef struct packed {
    logic              valid;
    logic [SLOT_W-1:0] data;
  } rsp_slot_t;

endpackage

// File: rtl/guvm_sync_fifo.sv
// Synchronous FIFO with registered occupancy and no write-to-read bypass.
// A pop frees its slot before a same-cycle push, so push+pop is accepted when full.
module guvm_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              do_push;
  logic              do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage carries data only; validity lives in the pointers and count.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/guvm_instr_feeder.sv
// Instruction-side responder feeding driver-queued words to a req/gnt/rvalid fetch port.
// Optional expected-PC check is built when GUVM_FEEDER_ADDR_CHECK_EN is defined. DATA_W up to 32.
module guvm_instr_feeder
  import guvm_feeder_pkg::*;
#(
  parameter int          DEPTH      = 16,
  parameter int          DATA_W     = 32,
  parameter int          RVALID_LAT = 1,
  parameter int          MAX_OUTST  = 2,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_RV32),
  parameter logic [31:0] BOOT_ADDR  = 32'h00000080
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   flush_i,
  input  logic                   push_valid_i,
  input  logic [DATA_W-1:0]      push_data_i,
  output logic                   push_ready_o,
  input  logic                   instr_req_i,
  input  logic [31:0]            instr_addr_i,
  output logic                   instr_gnt_o,
  output logic                   instr_rvalid_o,
  output logic [DATA_W-1:0]      instr_rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [15:0]            underflow_o,
  output logic                   addr_err_o
);

  localparam int OW = $clog2(MAX_OUTST + 1);

  feeder_state_e     state_q;
  logic [OW-1:0]     outst_q;
  logic [15:0]       uf_q;
  rsp_slot_t         slot_q [RVALID_LAT];
  rsp_slot_t         slot_d;
  rsp_slot_t         slot_out;

  logic              gnt;
  logic              rsp_vld;
  logic              fifo_push;
  logic              fifo_clear;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] grant_data;

  // Queued words are discarded on the edge that enters DRAIN; DRAIN refuses new words.
  assign fifo_clear = flush_i && (state_q != DRAIN);
  assign fifo_push  = push_valid_i && (state_q != DRAIN);

  guvm_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (fifo_clear),
    .push_i      (fifo_push),
    .push_data_i (push_data_i),
    .pop_i       (gnt),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (count_o)
  );

  assign push_ready_o = !fifo_full;
  assign gnt          = (state_q == RUN) && instr_req_i && (outst_q < OW'(MAX_OUTST));
  assign instr_gnt_o  = gnt;
  assign grant_data   = fifo_empty ? NOP_INSTR : fifo_head;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (flush_i) state_q <= DRAIN;
                 else if (enable_i) state_q <= RUN;
        RUN:     if (flush_i) state_q <= DRAIN;
        DRAIN:   if (outst_q == '0) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant stage: capture the word for this fetch into the head of the delay line.
  always_comb begin
    slot_d       = '0;
    slot_d.valid = gnt;
    slot_d.data  = SLOT_W'(grant_data);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RVALID_LAT; i++) slot_q[i] <= '0;
    end else begin
      slot_q[0] <= slot_d;
      for (int i = 1; i < RVALID_LAT; i++) slot_q[i] <= slot_q[i-1];
    end
  end

  // Response stage: the tail of the delay line drives rvalid/rdata.
  assign slot_out       = slot_q[RVALID_LAT-1];
  assign rsp_vld        = slot_out.valid;
  assign instr_rvalid_o = rsp_vld;
  assign instr_rdata_o  = rsp_vld ? slot_out.data[DATA_W-1:0] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst_q <= '0;
      uf_q    <= '0;
    end else begin
      case ({gnt, rsp_vld})
        2'b10:   outst_q <= outst_q + OW'(1);
        2'b01:   outst_q <= outst_q - OW'(1);
        default: outst_q <= outst_q;
      endcase
      if (gnt && fifo_empty && (uf_q != 16'hFFFF)) uf_q <= uf_q + 16'd1;
    end
  end

  assign underflow_o = uf_q;

`ifdef GUVM_FEEDER_ADDR_CHECK_EN
  logic [31:0] pc_q;
  logic        addr_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= BOOT_ADDR;
      addr_err_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && !flush_i && enable_i) pc_q <= BOOT_ADDR;
      else if (gnt) pc_q <= pc_q + 32'd4;
      if (gnt && (instr_addr_i != pc_q)) addr_err_q <= 1'b1;
    end
  end

  assign addr_err_o = addr_err_q;
`else
  logic unused_addr;
  assign unused_addr = ^{instr_addr_i, BOOT_ADDR};
  assign addr_err_o  = 1'b0;
`endif

endmodule
